dram: RTL and testbench

- Single-port synchronous data RAM with per-byte write enables.
- Provides 16384 x 32-bit storage (64 KiB) behind the data-memory bus decoder, which maps it at 0x0003_0000–0x0003_FFFF.
- Read data is registered, giving one-cycle latency; the bus wrapper inserts one wait state on reads to cover it.

---
 rtl/dram_pkg.sv | 12 +
 rtl/dram_if.sv | 40 ++++
 rtl/dram.sv | 68 ++++++
 tb/tb_dram.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared constants for the data RAM.
// DRAM_ADDR_W / DRAM_DATA_W set the default geometry (16384 x 32 bits).
// DRAM_BASE_ADDR is where the data-memory bus decoder maps this RAM.
// LANE_W is the width of one byte lane.
package dram_pkg;

    localparam int          DRAM_ADDR_W    = 14;
    localparam int          DRAM_DATA_W    = 32;
    localparam logic [31:0] DRAM_BASE_ADDR = 32'h0003_0000;
    localparam int          LANE_W         = 8;

endpackage : dram_pkg

// File: rtl/dram_if.sv
// Bus bundle for the data RAM port.
// Signals:
//   addra - word address (bus MADDR[15:2])
//   dina  - write data, lane i is bits [8i+7:8i]
//   douta - registered read data
//   ena   - port enable
//   wea   - per-byte write enables, qualified by ena
// Modports: master drives the request; slave is the RAM side.
interface dram_if
    import dram_pkg::*;
#(
    parameter int ADDR_W = DRAM_ADDR_W,
    parameter int DATA_W = DRAM_DATA_W
);

    localparam int NB = DATA_W / LANE_W;

    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              ena;
    logic [NB-1:0]     wea;

    modport master (
        output addra,
        output dina,
        output ena,
        output wea,
        input  douta
    );

    modport slave (
        input  addra,
        input  dina,
        input  ena,
        input  wea,
        output douta
    );

endinterface : dram_if

// File: rtl/dram.sv
// Single-port synchronous data RAM with per-byte write enables.
// Ports:
//   clka - clock, all activity on the rising edge
//   rsta - synchronous active-high reset of the output register only
//   bus  - dram_if slave modport (addra, dina, douta, ena, wea)
// Reads have one cycle of latency. A write cycle also updates douta with
// the post-write word (write-first). The storage array is never reset.
module dram
    import dram_pkg::*;
#(
    parameter int ADDR_W = DRAM_ADDR_W,
    parameter int DATA_W = DRAM_DATA_W
) (
    input  logic   clka,
    input  logic   rsta,
    dram_if.slave  bus
);

    localparam int NB    = DATA_W / LANE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    // Storage and output register both start at zero.
    logic [DATA_W-1:0] mem_r [0:DEPTH-1] = '{default: '0};
    logic [DATA_W-1:0] douta_r = '0;

    // Combine the stored word with the incoming data lane by lane.
    // Written lanes take new data; all other lanes keep the stored value.
    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     lane_we
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (lane_we[i]) begin
                res[LANE_W*i +: LANE_W] = new_word[LANE_W*i +: LANE_W];
            end else begin
                res[LANE_W*i +: LANE_W] = old_word[LANE_W*i +: LANE_W];
            end
        end
        return res;
    endfunction

    // Byte-lane writes and the write-first registered read.
    // rsta clears only douta and wins over the read update. A write in the
    // same edge still lands in memory.
    always_ff @(posedge clka) begin
        if (bus.ena) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wea[i]) begin
                    mem_r[bus.addra][LANE_W*i +: LANE_W] <= bus.dina[LANE_W*i +: LANE_W];
                end
            end
        end

        if (rsta) begin
            douta_r <= '0;
        end else if (bus.ena) begin
            douta_r <= merge_word(mem_r[bus.addra], bus.dina, bus.wea);
        end else begin
            douta_r <= douta_r;
        end
    end

    assign bus.douta = douta_r;

endmodule : dram

// File: tb/tb_dram.sv
// Scoreboard testbench for dram.
// A driver applies one directed vector per cycle. Where the vector carries
// an expected douta, that value is queued at the active edge. A monitor pops
// the queue on the following falling edge and compares it with douta.
module tb_dram;
    import dram_pkg::*;

    logic clka = 1'b0;
    logic rsta = 1'b0;

    dram_if #(.ADDR_W(DRAM_ADDR_W), .DATA_W(DRAM_DATA_W)) bus ();

    dram #(.ADDR_W(DRAM_ADDR_W), .DATA_W(DRAM_DATA_W)) dut (
        .clka (clka),
        .rsta (rsta),
        .bus  (bus.slave)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic        rst;
        logic        ena;
        logic [3:0]  wea;
        logic [13:0] addr;
        logic [31:0] din;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stim_done = 1'b0;

    function automatic void add(input logic rst, input logic ena, input logic [3:0] wea,
                                input logic [13:0] addr, input logic [31:0] din,
                                input logic chk, input logic [31:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.ena = ena; v.wea = wea; v.addr = addr;
        v.din = din; v.chk = chk; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    // Monitor: one expected value per falling edge, checked against douta.
    initial begin
        exp_t e;
        forever begin
            @(negedge clka);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (bus.douta !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: douta=%08h expected=%08h", e.name, bus.douta, e.exp);
                end
            end
        end
    end

    // Driver.
    initial begin
        exp_t e;
        bus.ena   = 1'b0;
        bus.wea   = 4'b0000;
        bus.addra = 14'h0000;
        bus.dina  = 32'h0000_0000;

        // Reset / idle
        add(1'b1, 1'b0, 4'b0000, 14'h0000, 32'h0000_0000, 1'b1, 32'h0000_0000, "reset_c1");
        add(1'b1, 1'b0, 4'b0000, 14'h0000, 32'h0000_0000, 1'b1, 32'h0000_0000, "reset_c2");
        add(1'b0, 1'b1, 4'b0000, 14'h0000, 32'h0000_0000, 1'b1, 32'h0000_0000, "read_zero");
        // Full write (write-first), then read
        add(1'b0, 1'b1, 4'b1111, 14'h0010, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, "full_write_wf");
        add(1'b0, 1'b1, 4'b0000, 14'h0010, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, "full_read");
        // Byte lanes 0 and 2
        add(1'b0, 1'b1, 4'b0101, 14'h0010, 32'h1122_3344, 1'b1, 32'hDE22_BE44, "lane_write_wf");
        add(1'b0, 1'b1, 4'b0000, 14'h0010, 32'h0000_0000, 1'b1, 32'hDE22_BE44, "lane_read");
        // Enable gating: douta loads 0 from address 0, then must hold it
        add(1'b0, 1'b1, 4'b0000, 14'h0000, 32'h0000_0000, 1'b1, 32'h0000_0000, "read_zero_again");
        add(1'b0, 1'b0, 4'b1111, 14'h0010, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, "ena0_hold_c1");
        add(1'b0, 1'b0, 4'b1111, 14'h0010, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, "ena0_hold_c2");
        add(1'b0, 1'b1, 4'b0000, 14'h0010, 32'h0000_0000, 1'b1, 32'hDE22_BE44, "ena0_mem_intact");
        // Reset mid-operation, including a write during reset
        add(1'b1, 1'b1, 4'b0000, 14'h0010, 32'h0000_0000, 1'b1, 32'h0000_0000, "rst_over_read");
        add(1'b0, 1'b1, 4'b0000, 14'h0010, 32'h0000_0000, 1'b1, 32'hDE22_BE44, "after_rst_read");
        add(1'b1, 1'b1, 4'b1000, 14'h0020, 32'hAA00_0000, 1'b1, 32'h0000_0000, "rst_with_write");
        add(1'b0, 1'b1, 4'b0000, 14'h0020, 32'h0000_0000, 1'b1, 32'hAA00_0000, "write_in_rst_kept");
        add(1'b0, 1'b1, 4'b0011, 14'h0020, 32'h5566_7788, 1'b1, 32'hAA00_7788, "lane_low_wf");
        add(1'b0, 1'b1, 4'b0000, 14'h0020, 32'h0000_0000, 1'b1, 32'hAA00_7788, "lane_low_read");
        // Extremes and back-to-back reads
        add(1'b0, 1'b1, 4'b1111, 14'h0000, 32'h0123_4567, 1'b1, 32'h0123_4567, "write_min");
        add(1'b0, 1'b1, 4'b1111, 14'h3FFF, 32'h89AB_CDEF, 1'b1, 32'h89AB_CDEF, "write_max");
        add(1'b0, 1'b1, 4'b0000, 14'h0000, 32'h0000_0000, 1'b1, 32'h0123_4567, "pipe_min_1");
        add(1'b0, 1'b1, 4'b0000, 14'h3FFF, 32'h0000_0000, 1'b1, 32'h89AB_CDEF, "pipe_max");
        add(1'b0, 1'b1, 4'b0000, 14'h0000, 32'h0000_0000, 1'b1, 32'h0123_4567, "pipe_min_2");
        add(1'b0, 1'b0, 4'b0000, 14'h0000, 32'h0000_0000, 1'b1, 32'h0123_4567, "idle_hold");

        // Power-up value before any reset or read
        #1;
        n_tests++;
        if (bus.douta !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL powerup: douta=%08h expected=00000000", bus.douta);
        end

        foreach (vecs[k]) begin
            @(negedge clka);
            rsta      = vecs[k].rst;
            bus.ena   = vecs[k].ena;
            bus.wea   = vecs[k].wea;
            bus.addra = vecs[k].addr;
            bus.dina  = vecs[k].din;
            @(posedge clka);
            if (vecs[k].chk) begin
                e.exp  = vecs[k].exp;
                e.name = vecs[k].name;
                exp_q.push_back(e);
            end
        end

        @(negedge clka);
        rsta    = 1'b0;
        bus.ena = 1'b0;
        bus.wea = 4'b0000;
        stim_done = 1'b1;
    end

    // Bounded end of test: anything left unchecked counts as a failure.
    initial begin
        wait (stim_done);
        repeat (3) @(negedge clka);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_dram
